led_shift_out: RTL and testbench

- Parametrised successor to the 8-bit sync-paced LED serialiser.
- Software or DMA writes words of DATA_WIDTH bits into an internal FIFO.
- The block shifts each word out one bit per sync event, in a configurable bit order and sync-edge mode.
- Back-to-back words stream with no gap; status outputs (busy, done, overflow, level) are added.
- Sits between the DMA/CPU bus and an LED pin. sync comes from an external bit-rate timer.

---
 rtl/led_pkg.sv | 16 +
 rtl/led_fifo.sv | 50 +++++
 rtl/led_shift_out.sv | 156 +++++++++++++++
 tb/tb_led_shift_out.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared encodings and constants for the sync-paced LED serialiser.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DRAIN
  } state_t;

  localparam int SYNC_ANY  = 0;
  localparam int SYNC_RISE = 1;
  localparam int SYNC_FALL = 2;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/led_fifo.sv
// Synchronous FIFO with level output; a write while full is dropped unless a pop frees the slot.
module led_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign wr_ok   = wr_en && (!full || rd_en);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_ok, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/led_shift_out.sv
// Serialises FIFO-buffered words onto led_out, one bit per qualified sync event.
module led_shift_out #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int SYNC_MODE  = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          sync,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_en,
  input  logic                          ovf_clr,
  output logic                          led_out,
  output logic                          dma,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import led_pkg::*;

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync_s, sync_prev, sync_evt, edge_ok;
  logic [1:0]             mask_cnt;

  logic                  full, empty, pop;
  logic [DATA_WIDTH-1:0] rd_data;

  state_t                state, state_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]         bit_cnt, cnt_d;
  logic                  led_d, busy_d, done_d, cur_bit;
  logic [DATA_WIDTH-1:0] shifted;

  led_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // The edge detector stays masked until the synchroniser has refilled after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_pipe <= '0;
      sync_prev <= 1'b0;
      mask_cnt  <= '0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], sync};
      sync_prev <= sync_s;
      if (mask_cnt != 2'd3) mask_cnt <= mask_cnt + 2'd1;
    end
  end

  assign sync_s = sync_pipe[SYNC_STAGES-1];

  always_comb begin
    case (SYNC_MODE)
      SYNC_RISE: edge_ok = sync_s & ~sync_prev;
      SYNC_FALL: edge_ok = ~sync_s & sync_prev;
      default:   edge_ok = sync_s ^ sync_prev;
    endcase
    sync_evt = edge_ok && (mask_cnt == 2'd3);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      dma      <= 1'b1;
    end else begin
      if (wr_en && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)          overflow <= 1'b0;
      dma <= (fifo_level != LW'(FIFO_DEPTH));
    end
  end

  assign cur_bit = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];
  assign shifted = MSB_FIRST ? {shreg[DATA_WIDTH-2:0], 1'b0} : {1'b0, shreg[DATA_WIDTH-1:1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      led_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= cnt_d;
      led_out <= led_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    shreg_d = shreg;
    cnt_d   = bit_cnt;
    led_d   = led_out;
    busy_d  = busy;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !empty) begin
          pop     = 1'b1;
          shreg_d = rd_data;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (sync_evt) begin
          led_d   = cur_bit;
          shreg_d = shifted;
          cnt_d   = bit_cnt + CW'(1);
          // Last bit: chain straight into the next word so the stream has no gap.
          if (bit_cnt == LAST) begin
            cnt_d = '0;
            if (enable && !empty) begin
              pop     = 1'b1;
              shreg_d = rd_data;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (sync_evt) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_shift_out.sv
// Directed scoreboard bench for led_shift_out: 8-bit MSB/any-edge and 12-bit LSB/rise-only instances.
module tb_led_shift_out;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en0 = 0, sync0 = 0, we0 = 0, clr0 = 0;
  logic [7:0] wd0 = '0;
  logic       led0, dma0, busy0, done0, ovf0;
  logic [2:0] lvl0;

  logic        en1 = 0, sync1 = 0, we1 = 0, clr1 = 0;
  logic [11:0] wd1 = '0;
  logic        led1, dma1, busy1, done1, ovf1;
  logic [2:0]  lvl1;

  led_shift_out #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b1), .SYNC_MODE(0)) dut0 (
    .clock(clk), .reset(rst), .enable(en0), .sync(sync0), .wr_data(wd0), .wr_en(we0),
    .ovf_clr(clr0), .led_out(led0), .dma(dma0), .busy(busy0), .done(done0),
    .overflow(ovf0), .fifo_level(lvl0));

  led_shift_out #(.DATA_WIDTH(12), .FIFO_DEPTH(4), .MSB_FIRST(1'b0), .SYNC_MODE(1)) dut1 (
    .clock(clk), .reset(rst), .enable(en1), .sync(sync1), .wr_data(wd1), .wr_en(we1),
    .ovf_clr(clr1), .led_out(led1), .dma(dma1), .busy(busy1), .done(done1),
    .overflow(ovf1), .fifo_level(lvl1));

  int total = 0;
  int bad   = 0;
  int dcnt0 = 0, dcnt1 = 0;
  logic exp0 [$];
  logic exp1 [$];

  always @(posedge clk) begin
    if (done0) dcnt0 <= dcnt0 + 1;
    if (done1) dcnt1 <= dcnt1 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr0(input logic [7:0] d);
    wd0 = d; we0 = 1'b1;
    tick(1);
    we0 = 1'b0;
  endtask

  task automatic wr1(input logic [11:0] d);
    wd1 = d; we1 = 1'b1;
    tick(1);
    we1 = 1'b0;
  endtask

  task automatic push0(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) exp0.push_back(d[i]);
  endtask

  task automatic push1(input logic [11:0] d);
    for (int i = 0; i < 12; i++) exp1.push_back(d[i]);
  endtask

  task automatic bit0(input string tag);
    logic e;
    sync0 = ~sync0;
    tick(6);
    if (exp0.size() == 0) begin
      total++; bad++;
      $error("FAIL %s observed=queue_empty expected=bit", tag);
    end else begin
      e = exp0.pop_front();
      chk(tag, 32'(led0), 32'(e));
    end
  endtask

  initial begin
    int d0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_led0", 32'(led0), 0);
    chk("rst_dma0", 32'(dma0), 1);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_ovf0", 32'(ovf0), 0);
    chk("rst_lvl0", 32'(lvl0), 0);
    chk("rst_dma1", 32'(dma1), 1);
    chk("rst_lvl1", 32'(lvl1), 0);
    tick(4);

    // 8'hA5 MSB first, any-edge
    en0 = 1'b1;
    push0(8'hA5);
    wr0(8'hA5);
    tick(3);
    chk("a5_busy", 32'(busy0), 1);
    chk("a5_lvl", 32'(lvl0), 0);
    chk("a5_nofirst", 32'(led0), 0);
    for (int i = 0; i < 8; i++) bit0("a5_bit");
    d0 = dcnt0;
    sync0 = ~sync0;
    tick(6);
    chk("a5_done", 32'(dcnt0 - d0), 1);
    chk("a5_idle", 32'(busy0), 0);
    chk("a5_hold", 32'(led0), 1);

    // FIFO fill / overflow with sync still
    en0 = 1'b0;
    wr0(8'h01); wr0(8'h02); wr0(8'h03);
    tick(2);
    chk("fill3_dma", 32'(dma0), 1);
    wr0(8'h04);
    tick(2);
    chk("fill4_dma", 32'(dma0), 0);
    chk("fill4_lvl", 32'(lvl0), 4);
    chk("fill4_ovf", 32'(ovf0), 0);
    wr0(8'h05);
    chk("ovf_set", 32'(ovf0), 1);
    chk("ovf_lvl", 32'(lvl0), 4);
    clr0 = 1'b1;
    tick(1);
    clr0 = 1'b0;
    chk("ovf_clr", 32'(ovf0), 0);

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("rst2_lvl", 32'(lvl0), 0);
    tick(4);

    // enable dropped after 3 bits with two words queued
    wr0(8'h3C); wr0(8'h81);
    en0 = 1'b1;
    tick(3);
    chk("en_lvl1", 32'(lvl0), 1);
    chk("en_busy", 32'(busy0), 1);
    push0(8'h3C);
    for (int i = 0; i < 3; i++) bit0("en_bit");
    en0 = 1'b0;
    for (int i = 0; i < 5; i++) bit0("en_bit");
    d0 = dcnt0;
    sync0 = ~sync0;
    tick(6);
    chk("en_done", 32'(dcnt0 - d0), 1);
    chk("en_idle", 32'(busy0), 0);
    chk("en_lvl_end", 32'(lvl0), 1);

    // 12-bit LSB first, rising edges only, two words seamless
    en1 = 1'b1;
    push1(12'h00F); push1(12'hF00);
    wr1(12'h00F); wr1(12'hF00);
    tick(3);
    for (int i = 0; i < 24; i++) begin
      logic e;
      sync1 = 1'b1;
      tick(6);
      e = (exp1.size() != 0) ? exp1.pop_front() : 1'bx;
      chk("w12_rise", 32'(led1), 32'(e));
      chk("w12_busy", 32'(busy1), 1);
      sync1 = 1'b0;
      tick(6);
      chk("w12_fall", 32'(led1), 32'(e));
    end
    d0 = dcnt1;
    sync1 = 1'b1;
    tick(6);
    chk("w12_done", 32'(dcnt1 - d0), 1);
    chk("w12_idle", 32'(busy1), 0);

    // reset mid-word, then sync held high through release
    en0 = 1'b1;
    tick(3);
    push0(8'h81);
    wr0(8'h55);
    for (int i = 0; i < 4; i++) bit0("mid_bit");
    rst = 1'b1;
    sync0 = 1'b1;
    tick(1);
    chk("mid_led", 32'(led0), 0);
    chk("mid_busy", 32'(busy0), 0);
    chk("mid_lvl", 32'(lvl0), 0);
    chk("mid_dma", 32'(dma0), 1);
    exp0.delete();
    tick(1);
    rst = 1'b0;
    wr0(8'hFF);
    tick(10);
    chk("post_led", 32'(led0), 0);
    chk("post_busy", 32'(busy0), 1);
    chk("post_lvl", 32'(lvl0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
